sd_sector_reader: RTL and testbench

//  Single-block SD read sequencer sitting directly upstream of the sd/spi byte engine.
//  On request it drives CMD17 over the engine, polls R1, waits for the data token,

---
 rtl/sd_sector_reader_if.sv | 28 ++
 rtl/sd_sector_reader.sv | 194 +++++++++++++++++++
 tb/tb_sd_sector_reader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_reader_if.sv
// Sector-reader bus: CPU request/status, sector buffer write port and SPI byte-engine port.
// slave = the reader itself, master = whatever drives/observes it.
interface sd_sector_reader_if;
  logic        req;
  logic [31:0] lba;
  logic        block_addr;
  logic        busy;
  logic        done;
  logic [2:0]  err_code;
  logic [7:0]  r1;
  logic        buf_we;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_wdata;
  logic [7:0]  spi_din;
  logic        spi_start;
  logic        spi_busy;
  logic [7:0]  spi_dout;
  logic        spi_cs;

  modport slave (
    input  req, lba, block_addr, spi_busy, spi_dout,
    output busy, done, err_code, r1, buf_we, buf_addr, buf_wdata, spi_din, spi_start, spi_cs
  );
  modport master (
    output req, lba, block_addr, spi_busy, spi_dout,
    input  busy, done, err_code, r1, buf_we, buf_addr, buf_wdata, spi_din, spi_start, spi_cs
  );
endinterface

// File: rtl/sd_sector_reader.sv
// Single-block SD read sequencer: CMD17, R1 poll, token wait, 512 data bytes into the
// sector buffer, CRC discard, then a chip-deselected dummy byte before reporting done.
module sd_sector_reader #(
  parameter int R1_TRIES    = 8,
  parameter int TOKEN_TRIES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  sd_sector_reader_if.slave bus
);
  localparam int CMAX = (TOKEN_TRIES > 512) ? TOKEN_TRIES : 512;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] CMD_LAST  = CW'(5);
  localparam logic [CW-1:0] R1_LAST   = CW'(R1_TRIES - 1);
  localparam logic [CW-1:0] TOK_LAST  = CW'(TOKEN_TRIES - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(511);
  localparam logic [CW-1:0] CRC_LAST  = CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_TAIL} state_t;
  // Per-byte handshake: start pulse, one blind cycle, then wait for engine idle.
  typedef enum logic [1:0] {PH_START, PH_HOLD, PH_WAIT} phase_t;

  state_t          state_q, state_d;
  phase_t          ph_q, ph_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     arg_q, arg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2:0]      err_q, err_d;
  logic [7:0]      r1_q, r1_d;
  logic            we_q, we_d;
  logic [8:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            cs_q, cs_d;
  logic            xfer_done;
  logic [7:0]      din;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ph_q    <= PH_START;
      cnt_q   <= '0;
      arg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 3'd0;
      r1_q    <= 8'hFF;
      we_q    <= 1'b0;
      addr_q  <= 9'd0;
      wdata_q <= 8'h00;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      arg_q   <= arg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      r1_q    <= r1_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cs_q    <= cs_d;
    end
  end

  assign xfer_done = (state_q != S_IDLE) && (ph_q == PH_WAIT) && !bus.spi_busy;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    arg_d   = arg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    r1_d    = r1_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cs_d    = cs_q;

    if (state_q != S_IDLE) begin
      case (ph_q)
        PH_START: ph_d = PH_HOLD;
        PH_HOLD:  ph_d = PH_WAIT;
        default:  if (!bus.spi_busy) ph_d = PH_START;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        // A req landing in the done cycle is dropped, not queued.
        if (bus.req && !done_q) begin
          arg_d   = bus.block_addr ? bus.lba : (bus.lba << 9);
          err_d   = 3'd0;
          r1_d    = 8'hFF;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          cnt_d   = '0;
          ph_d    = PH_START;
          state_d = S_CMD;
        end
      end
      S_CMD: if (xfer_done) begin
        if (cnt_q == CMD_LAST) begin
          cnt_d   = '0;
          state_d = S_R1;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_R1: if (xfer_done) begin
        if (!bus.spi_dout[7]) begin
          r1_d = bus.spi_dout;
          cnt_d = '0;
          if (bus.spi_dout == 8'h00) state_d = S_TOKEN;
          else begin
            err_d   = 3'd2;
            cs_d    = 1'b1;
            state_d = S_TAIL;
          end
        end else if (cnt_q == R1_LAST) begin
          err_d   = 3'd1;
          cs_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_TAIL;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_TOKEN: if (xfer_done) begin
        if (bus.spi_dout == 8'hFE) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else if (bus.spi_dout != 8'hFF) begin
          err_d   = 3'd4;
          cs_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_TAIL;
        end else if (cnt_q == TOK_LAST) begin
          err_d   = 3'd3;
          cs_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_TAIL;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_DATA: if (xfer_done) begin
        we_d    = 1'b1;
        addr_d  = cnt_q[8:0];
        wdata_d = bus.spi_dout;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = S_CRC;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_CRC: if (xfer_done) begin
        if (cnt_q == CRC_LAST) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          state_d = S_TAIL;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_TAIL: if (xfer_done) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    din = 8'hFF;
    if (state_q == S_CMD) begin
      case (cnt_q[2:0])
        3'd0:    din = 8'h51;
        3'd1:    din = arg_q[31:24];
        3'd2:    din = arg_q[23:16];
        3'd3:    din = arg_q[15:8];
        3'd4:    din = arg_q[7:0];
        default: din = 8'hFF;
      endcase
    end
  end

  assign bus.spi_start = (state_q != S_IDLE) && (ph_q == PH_START);
  assign bus.spi_din   = din;
  assign bus.spi_cs    = cs_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_code  = err_q;
  assign bus.r1        = r1_q;
  assign bus.buf_we    = we_q;
  assign bus.buf_addr  = addr_q;
  assign bus.buf_wdata = wdata_q;
endmodule

// File: tb/tb_sd_sector_reader.sv
// Bench for sd_sector_reader: SPI engine + SD card model fed from a reply queue,
// directed table of transactions, randomized transactions, reset and req-ignore corners.
module tb_sd_sector_reader;
  localparam int R1T = 8;
  localparam int TT  = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_sector_reader_if bus();
  sd_sector_reader #(.R1_TRIES(R1T), .TOKEN_TRIES(TT)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] lba;
    bit          blk;
    int          r1_ff;
    logic [7:0]  r1_val;
    int          tok_ff;
    logic [7:0]  tok_val;
    logic [2:0]  exp_err;
    logic [7:0]  exp_r1;
    int          exp_bytes;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  rq[$];
  logic [7:0]  mosi[$];
  logic [7:0]  exp_data[512];
  int          tail_cnt, rise_cnt, done_cnt, wr_cnt;
  bit          wr_bad;
  logic        prev_cs = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Byte engine + card: each start pops the next scripted MISO byte while selected.
  initial begin : engine
    logic [7:0] rep;
    int l;
    bus.spi_busy = 1'b0;
    bus.spi_dout = 8'hFF;
    forever begin
      @(negedge clk);
      if (bus.spi_start === 1'b1) begin
        if (bus.spi_cs === 1'b0) begin
          mosi.push_back(bus.spi_din);
          rep = (rq.size() > 0) ? rq.pop_front() : 8'hFF;
        end else begin
          tail_cnt++;
          rep = 8'hFF;
        end
        bus.spi_busy = 1'b1;
        bus.spi_dout = 8'($urandom);
        l = $urandom_range(1, 3);
        repeat (l) @(negedge clk);
        bus.spi_busy = 1'b0;
        bus.spi_dout = rep;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.buf_we === 1'b1) begin
        if (wr_cnt >= 512 || bus.buf_addr !== 9'(wr_cnt) || bus.buf_wdata !== exp_data[wr_cnt])
          wr_bad = 1'b1;
        wr_cnt++;
      end
      if (bus.done === 1'b1) done_cnt++;
      if (bus.spi_cs === 1'b1 && prev_cs === 1'b0) rise_cnt++;
      prev_cs = bus.spi_cs;
    end
  end

  // Reference outcome straight from the protocol rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.r1_ff >= R1T) begin
      r.exp_err = 3'd1; r.exp_r1 = 8'hFF; r.exp_bytes = 6 + R1T;
    end else begin
      r.exp_r1 = v.r1_val;
      r.exp_bytes = 6 + v.r1_ff + 1;
      if (v.r1_val != 8'h00) r.exp_err = 3'd2;
      else if (v.tok_ff >= TT) begin
        r.exp_err = 3'd3; r.exp_bytes += TT;
      end else if (v.tok_val == 8'hFE) begin
        r.exp_err = 3'd0; r.exp_bytes += v.tok_ff + 1 + 514;
      end else begin
        r.exp_err = 3'd4; r.exp_bytes += v.tok_ff + 1;
      end
    end
    return r;
  endfunction

  task automatic load(input vec_t v, input bit rnd);
    rq.delete(); mosi.delete();
    tail_cnt = 0; rise_cnt = 0; done_cnt = 0; wr_cnt = 0; wr_bad = 1'b0;
    for (int i = 0; i < 512; i++) exp_data[i] = rnd ? 8'($urandom) : 8'(i);
    repeat (6) rq.push_back(8'hFF);
    if (v.r1_ff < R1T) begin
      repeat (v.r1_ff) rq.push_back(8'hFF);
      rq.push_back(v.r1_val);
      if (v.r1_val == 8'h00 && v.tok_ff < TT) begin
        repeat (v.tok_ff) rq.push_back(8'hFF);
        rq.push_back(v.tok_val);
        if (v.tok_val == 8'hFE) begin
          for (int i = 0; i < 512; i++) rq.push_back(exp_data[i]);
          rq.push_back(8'hA5);
          rq.push_back(8'h5A);
        end
      end
    end
  endtask

  task automatic issue_req(input vec_t v);
    @(negedge clk);
    bus.req = 1'b1; bus.lba = v.lba; bus.block_addr = v.blk;
    @(negedge clk);
    bus.req = 1'b0; bus.lba = ~v.lba; bus.block_addr = ~v.blk;
    chk("busy_after_req", 32'(bus.busy), 32'd1);
  endtask

  task automatic run(input vec_t v, input bit rnd, input bit req_busy, input bit req_done, input string tag);
    int cyc;
    logic [31:0] arg;
    logic [7:0] cmd[6];
    bit ok;
    load(v, rnd);
    issue_req(v);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 60000) begin
      bus.req = (req_busy && cyc == 3);
      @(negedge clk);
      cyc++;
    end
    bus.req = 1'b0;
    if (cyc >= 60000) begin
      n_chk++; n_fail++;
      $display("FAIL %s done_timeout: no done after %0d cycles", tag, cyc);
    end
    if (req_done) begin
      bus.req = 1'b1;
      @(negedge clk);
      bus.req = 1'b0;
    end
    repeat (4) @(negedge clk);
    arg = v.blk ? v.lba : (v.lba << 9);
    cmd[0] = 8'h51; cmd[1] = arg[31:24]; cmd[2] = arg[23:16];
    cmd[3] = arg[15:8]; cmd[4] = arg[7:0]; cmd[5] = 8'hFF;
    chk({tag, " done_once"}, 32'(done_cnt), 32'd1);
    chk({tag, " busy_low"}, 32'(bus.busy), 32'd0);
    chk({tag, " err_code"}, 32'(bus.err_code), 32'(v.exp_err));
    chk({tag, " r1"}, 32'(bus.r1), 32'(v.exp_r1));
    chk({tag, " cs_low_bytes"}, 32'(mosi.size()), 32'(v.exp_bytes));
    if (mosi.size() >= 6)
      for (int i = 0; i < 6; i++) chk({tag, " mosi_cmd"}, 32'(mosi[i]), 32'(cmd[i]));
    ok = 1'b1;
    for (int i = 6; i < mosi.size(); i++) if (mosi[i] !== 8'hFF) ok = 1'b0;
    chk({tag, " mosi_poll_ff"}, 32'(ok), 32'd1);
    chk({tag, " buf_writes"}, 32'(wr_cnt), (v.exp_err == 3'd0) ? 32'd512 : 32'd0);
    chk({tag, " buf_content"}, 32'(wr_bad), 32'd0);
    chk({tag, " tail_dummy_cs_high"}, 32'(tail_cnt), 32'd1);
    chk({tag, " cs_single_rise"}, 32'(rise_cnt), 32'd1);
    chk({tag, " cs_idle_high"}, 32'(bus.spi_cs), 32'd1);
  endtask

  vec_t tbl[6];
  vec_t v;

  initial begin
    bus.req = 1'b0; bus.lba = '0; bus.block_addr = 1'b0;
    reset = 1'b1;
    tbl[0] = '{32'h1,        1'b0, 2,   8'h00, 3,    8'hFE, 3'd0, 8'h00, 527};
    tbl[1] = '{32'h12345678, 1'b1, 2,   8'h00, 3,    8'hFE, 3'd0, 8'h00, 527};
    tbl[2] = '{32'h7,        1'b1, 100, 8'h00, 0,    8'hFE, 3'd1, 8'hFF, 14};
    tbl[3] = '{32'h20,       1'b0, 2,   8'h04, 0,    8'hFE, 3'd2, 8'h04, 9};
    tbl[4] = '{32'h21,       1'b1, 0,   8'h00, 1,    8'h08, 3'd4, 8'h00, 9};
    tbl[5] = '{32'h22,       1'b1, 0,   8'h00, 5000, 8'hFE, 3'd3, 8'h00, 4103};
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst err_code", 32'(bus.err_code), 32'd0);
    chk("rst r1", 32'(bus.r1), 32'hFF);
    chk("rst buf_we", 32'(bus.buf_we), 32'd0);
    chk("rst buf_addr", 32'(bus.buf_addr), 32'd0);
    chk("rst buf_wdata", 32'(bus.buf_wdata), 32'd0);
    chk("rst spi_start", 32'(bus.spi_start), 32'd0);
    chk("rst spi_din", 32'(bus.spi_din), 32'hFF);
    chk("rst spi_cs", 32'(bus.spi_cs), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run(tbl[i], 1'b0, 1'b0, (i == 3), $sformatf("dir%0d", i));

    // Reset in the middle of the data phase.
    load(tbl[0], 1'b0);
    issue_req(tbl[0]);
    for (int c = 0; c < 5000 && wr_cnt < 100; c++) @(negedge clk);
    chk("mid_reset reached_byte100", 32'(wr_cnt >= 100), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset cs_high", 32'(bus.spi_cs), 32'd1);
    chk("mid_reset busy_low", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_reset no_done", 32'(done_cnt), 32'd0);
    run(tbl[1], 1'b0, 1'b1, 1'b0, "post_reset");

    for (int n = 0; n < 6; n++) begin
      v.lba     = $urandom;
      v.blk     = 1'($urandom);
      v.r1_ff   = $urandom_range(0, 10);
      v.r1_val  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 127)) : 8'h00;
      v.tok_ff  = $urandom_range(0, 20);
      v.tok_val = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 253)) : 8'hFE;
      v = model(v);
      run(v, 1'b1, 1'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
